// File: rtl/ps2_note_scanner.sv
// PS/2 keyboard front end: line conditioning, 11-bit frame deframer with
// watchdog, and make/break/extended decoding into a 10-key held-note bitmap.

module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic filt
);
  localparam int FW = $clog2(FILTER_LEN + 1);

  logic [1:0]    sync;
  logic [FW-1:0] cnt;

  // The counter holds the run length of samples disagreeing with filt; the
  // FILTER_LEN-th consecutive disagreeing sample flips the output.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= 2'b11;
      cnt  <= '0;
      filt <= 1'b1;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == filt)
        cnt <= '0;
      else if (cnt == FW'(FILTER_LEN - 1)) begin
        filt <= sync[1];
        cnt  <= '0;
      end else
        cnt <= cnt + 1'b1;
    end
  end
endmodule

module ps2_note_scanner #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_err,
  output logic [9:0] notes,
  output logic       notes_valid
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0] raw_lines, filt;
  logic       clk_f, data_f, clk_q, fall;

  assign raw_lines = {ps2_data, ps2_clk};

  generate
    for (genvar i = 0; i < 2; i++) begin : g_filt
      ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
        .clk  (clk),
        .rst  (rst),
        .raw  (raw_lines[i]),
        .filt (filt[i])
      );
    end
  endgenerate

  assign clk_f  = filt[0];
  assign data_f = filt[1];
  assign fall   = clk_q & ~clk_f;

  state_t        state, state_nx;
  logic [2:0]    bit_cnt, bit_cnt_nx;
  logic [7:0]    shreg, shreg_nx;
  logic          par, par_nx;
  logic [TW-1:0] wd;
  logic          timeout, frame_ok, frame_bad;

  // A falling edge in the same cycle always beats the watchdog.
  assign timeout = (state != IDLE) && !fall && (wd == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_nx   = state;
    bit_cnt_nx = bit_cnt;
    shreg_nx   = shreg;
    par_nx     = par;
    frame_ok   = 1'b0;
    frame_bad  = 1'b0;
    case (state)
      IDLE:
        if (fall && !data_f) begin
          state_nx   = DATA;
          bit_cnt_nx = 3'd0;
        end
      DATA:
        if (fall) begin
          shreg_nx   = {data_f, shreg[7:1]};
          bit_cnt_nx = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nx = PARITY;
        end
      PARITY:
        if (fall) begin
          par_nx   = data_f;
          state_nx = STOP;
        end
      STOP:
        if (fall) begin
          state_nx = IDLE;
          if ((^{shreg, par}) && data_f) frame_ok = 1'b1;
          else                           frame_bad = 1'b1;
        end
      default: state_nx = IDLE;
    endcase
    if (timeout) begin
      state_nx  = IDLE;
      frame_bad = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      par        <= 1'b0;
      clk_q      <= 1'b1;
      wd         <= '0;
      scan_code  <= '0;
      scan_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_nx;
      bit_cnt    <= bit_cnt_nx;
      shreg      <= shreg_nx;
      par        <= par_nx;
      clk_q      <= clk_f;
      wd         <= (state == IDLE || fall) ? '0 : wd + 1'b1;
      scan_valid <= frame_ok;
      frame_err  <= frame_bad;
      if (frame_ok) scan_code <= shreg;
    end
  end

  // Key decoder
  logic       brk, ext, brk_nx, ext_nx, hit;
  logic [3:0] idx;
  logic [9:0] notes_nx;

  always_comb begin
    hit = 1'b1;
    idx = 4'd0;
    case (scan_code)
      8'h15: idx = 4'd0;
      8'h1D: idx = 4'd1;
      8'h24: idx = 4'd2;
      8'h2D: idx = 4'd3;
      8'h2C: idx = 4'd4;
      8'h35: idx = 4'd5;
      8'h3C: idx = 4'd6;
      8'h43: idx = 4'd7;
      8'h44: idx = 4'd8;
      8'h4D: idx = 4'd9;
      default: hit = 1'b0;
    endcase
  end

  always_comb begin
    notes_nx = notes;
    brk_nx   = brk;
    ext_nx   = ext;
    if (frame_err) begin
      brk_nx = 1'b0;
      ext_nx = 1'b0;
    end else if (scan_valid) begin
      if (scan_code == 8'hF0)
        brk_nx = 1'b1;
      else if (scan_code == 8'hE0)
        ext_nx = 1'b1;
      else begin
        if (hit && !ext) notes_nx[idx] = ~brk;
        brk_nx = 1'b0;
        ext_nx = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      brk         <= 1'b0;
      ext         <= 1'b0;
      notes       <= '0;
      notes_valid <= 1'b0;
    end else begin
      brk         <= brk_nx;
      ext         <= ext_nx;
      notes       <= notes_nx;
      notes_valid <= (notes_nx != notes);
    end
  end
endmodule
